// File: rtl/axis_byte_bridge.sv
// Byte <-> word bridge between an 8-bit host stream and the processor's AXI-Stream ports.
// RX packs bytes MSB-first into INP_WIDTH words; TX unpacks OUT_WIDTH words MSB-first into bytes.
module axis_byte_bridge #(
   parameter int INP_WIDTH = 16,
   parameter int OUT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 arstn,
   input  logic [7:0]           rx_tdata,
   input  logic                 rx_tvalid,
   output logic                 rx_tready,
   output logic [INP_WIDTH-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   input  logic [OUT_WIDTH-1:0] s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic [7:0]           tx_tdata,
   output logic                 tx_tvalid,
   input  logic                 tx_tready
);

   localparam int INP_BYTES = INP_WIDTH / 8;
   localparam int OUT_BYTES = OUT_WIDTH / 8;
   localparam int RX_CW     = (INP_BYTES > 1) ? $clog2(INP_BYTES) : 1;
   localparam int TX_CW     = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

   // ---------------- RX: deserialiser ----------------
   logic [INP_WIDTH-1:0] rx_word_reg, rx_word_next;
   logic [RX_CW-1:0]     rx_cnt_reg, rx_cnt_next;
   logic                 m_valid_reg, m_valid_next;
   logic                 rx_hs;
   logic                 rx_last;

   assign rx_tready     = !m_valid_reg || m_axis_tready;
   assign rx_hs         = rx_tvalid && rx_tready;
   assign rx_last       = (rx_cnt_reg == RX_CW'(INP_BYTES - 1));
   assign m_axis_tdata  = rx_word_reg;
   assign m_axis_tvalid = m_valid_reg;

   // Bytes are only accepted while the held word is absent or leaving, so the word stays stable.
   always_comb begin
      rx_word_next = rx_word_reg;
      rx_cnt_next  = rx_cnt_reg;
      m_valid_next = m_valid_reg;
      if (m_axis_tready) m_valid_next = 1'b0;
      if (rx_hs) begin
         rx_word_next = INP_WIDTH'({rx_word_reg, rx_tdata});
         rx_cnt_next  = rx_last ? '0 : RX_CW'(rx_cnt_reg + 1'b1);
         if (rx_last) m_valid_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!arstn) begin
         rx_word_reg <= '0;
         rx_cnt_reg  <= '0;
         m_valid_reg <= 1'b0;
      end else begin
         rx_word_reg <= rx_word_next;
         rx_cnt_reg  <= rx_cnt_next;
         m_valid_reg <= m_valid_next;
      end
   end

   // ---------------- TX: serialiser ----------------
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

   tx_state_t            state_reg, state_next;
   logic [OUT_WIDTH-1:0] tx_shift_reg, tx_shift_next;
   logic [TX_CW-1:0]     tx_cnt_reg, tx_cnt_next;
   logic                 tx_last;
   logic                 tx_load;
   logic                 tx_shift_en;

   assign tx_last  = (tx_cnt_reg == TX_CW'(OUT_BYTES - 1));
   assign tx_tdata = tx_shift_reg[OUT_WIDTH-1 -: 8];

   always_ff @(posedge clk) begin
      if (!arstn) state_reg <= TX_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         TX_IDLE: if (tx_load) state_next = TX_SEND;
         TX_SEND: if (tx_shift_en && tx_last && !tx_load) state_next = TX_IDLE;
         default: state_next = TX_IDLE;
      endcase
   end

   // The last byte's handshake also opens s_axis so a waiting word follows without a bubble.
   always_comb begin
      tx_tvalid     = (state_reg == TX_SEND);
      tx_shift_en   = tx_tvalid && tx_tready;
      s_axis_tready = (state_reg == TX_IDLE) || (tx_shift_en && tx_last);
      tx_load       = s_axis_tvalid && s_axis_tready;
   end

   always_comb begin
      tx_shift_next = tx_shift_reg;
      tx_cnt_next   = tx_cnt_reg;
      if (tx_load) begin
         tx_shift_next = s_axis_tdata;
         tx_cnt_next   = '0;
      end else if (tx_shift_en) begin
         tx_shift_next = tx_shift_reg << 8;
         tx_cnt_next   = TX_CW'(tx_cnt_reg + 1'b1);
      end
   end

   always_ff @(posedge clk) begin
      if (!arstn) begin
         tx_shift_reg <= '0;
         tx_cnt_reg   <= '0;
      end else begin
         tx_shift_reg <= tx_shift_next;
         tx_cnt_reg   <= tx_cnt_next;
      end
   end

endmodule
